// File: rtl/icache_pkg.sv
// icache_pkg: bus structs, default geometry, meta entry and FSM state types for icache_assoc.
package icache_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [7:0]  len;
    logic [1:0]  burst;
  } cbus_req_t;
  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
  localparam logic [2:0] MSIZE8 = 3'd3;
  localparam logic [1:0] BURST_INCR = 2'd1;
  localparam int NUM_WAYS_D = 2;
  localparam int NUM_SETS_D = 16;
  localparam int LINE_BEATS_D = 4;
  localparam int OFFSET_W = $clog2(8 * LINE_BEATS_D);
  localparam int INDEX_W = $clog2(NUM_SETS_D);
  localparam int TAG_W = 64 - OFFSET_W - INDEX_W;
  localparam int WAY_W = $clog2(NUM_WAYS_D);
  // tag is kept as the full right-shifted address so one entry type fits every geometry
  typedef struct packed {
    logic        valid;
    logic [63:0] tag;
  } meta_t;
  typedef enum logic [2:0] {IDLE, COMPARE, REFILL, RESPOND, FLUSH} state_t;
endpackage

// File: rtl/icache_if.sv
// icache_if: fetch-side (ibus) and memory-side (cbus) signals of the instruction cache.
interface icache_if import icache_pkg::*; ();
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  cbus_req_t  creq;
  cbus_resp_t cresp;
  modport master (output ireq, output cresp, input iresp, input creq);
  modport slave (input ireq, input cresp, output iresp, output creq);
endinterface

// File: rtl/icache_way.sv
// icache_way: one way's valid/tag and line storage with combinational read and tag match.
module icache_way import icache_pkg::*; #(
  parameter int NUM_SETS = 16,
  parameter int LINE_BEATS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [$clog2(NUM_SETS)-1:0]   index,
  input  logic [63:0]                   tag,
  input  logic                          we,
  input  logic                          flush,
  input  logic [LINE_BEATS-1:0][63:0]   wline,
  output logic                          valid,
  output logic                          hit,
  output logic [LINE_BEATS-1:0][63:0]   line
);
  meta_t meta_q [NUM_SETS];
  logic [LINE_BEATS-1:0][63:0] data_q [NUM_SETS];
  always_ff @(posedge clk or negedge reset)
    if (!reset)
      for (int i = 0; i < NUM_SETS; i++) meta_q[i] <= '0;
    else if (flush)
      for (int i = 0; i < NUM_SETS; i++) meta_q[i].valid <= 1'b0;
    else if (we)
      meta_q[index] <= '{valid: 1'b1, tag: tag};
  always_ff @(posedge clk)
    if (we) data_q[index] <= wline;
  assign valid = meta_q[index].valid;
  assign hit = valid && meta_q[index].tag == tag;
  assign line = data_q[index];
endmodule

// File: rtl/icache_assoc.sv
// icache_assoc: set-associative read-only icache with round-robin refill and fence.i flush.
// Define ICACHE_PERF_EN to add saturating hit_cnt/miss_cnt outputs.
module icache_assoc import icache_pkg::*; #(
  parameter int NUM_WAYS = 2,
  parameter int NUM_SETS = 16,
  parameter int LINE_BEATS = 4
) (
  input  logic        clk,
  input  logic        reset,
  icache_if.slave     bus,
  input  logic        fence_i
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);
  localparam int OW = $clog2(8 * LINE_BEATS);
  localparam int IW = $clog2(NUM_SETS);
  localparam int BW = $clog2(LINE_BEATS);
  localparam int WW = NUM_WAYS > 1 ? $clog2(NUM_WAYS) : 1;
  typedef logic [LINE_BEATS-1:0][63:0] line_t;
  state_t state_q, state_d;
  logic [63:0] addr_q, tag;
  logic [IW-1:0] idx;
  logic [BW-1:0] beat_q;
  line_t buf_q, fill_line, hit_line;
  line_t lines [NUM_WAYS];
  logic pend_q, hit, use_ptr, fill_done, flush, beat_ok;
  logic [NUM_WAYS-1:0] hits, valids, we;
  logic [WW-1:0] vway;
  logic [WW-1:0] victim_q [NUM_SETS];
  assign idx = addr_q[OW +: IW];
  assign tag = addr_q >> (OW + IW);
  assign beat_ok = state_q == REFILL && bus.cresp.ready;
  assign fill_done = beat_ok && bus.cresp.last;
  assign flush = state_q == FLUSH;
  assign hit = |hits;
  assign we = fill_done ? NUM_WAYS'(1) << vway : '0;
  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    icache_way #(.NUM_SETS(NUM_SETS), .LINE_BEATS(LINE_BEATS)) u_way (
      .clk(clk), .reset(reset), .index(idx), .tag(tag), .we(we[w]), .flush(flush),
      .wline(fill_line), .valid(valids[w]), .hit(hits[w]), .line(lines[w]));
  end
  function automatic logic [31:0] pick(line_t l, logic [63:0] a);
    return a[2] ? l[a[3 +: BW]][63:32] : l[a[3 +: BW]][31:0];
  endfunction
  // descending scan leaves the lowest-numbered invalid way as victim
  always_comb begin
    hit_line = '0;
    use_ptr = 1'b1;
    vway = victim_q[idx];
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (hits[w]) hit_line = hit_line | lines[w];
      if (!valids[w]) begin
        vway = WW'(w);
        use_ptr = 1'b0;
      end
    end
    fill_line = buf_q;
    fill_line[beat_q] = bus.cresp.data;
    if (state_q == COMPARE) assert ($onehot0(hits));
  end
  always_comb begin
    state_d = state_q;
    bus.iresp = '0;
    bus.creq = '0;
    unique case (state_q)
      IDLE: state_d = (fence_i || pend_q) ? FLUSH : bus.ireq.valid ? COMPARE : IDLE;
      COMPARE: begin
        if (hit) bus.iresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: pick(hit_line, addr_q)};
        state_d = hit ? IDLE : REFILL;
      end
      REFILL: begin
        bus.creq = '{valid: 1'b1, is_write: 1'b0, size: MSIZE8, addr: {addr_q[63:OW], {OW{1'b0}}},
                     strobe: 8'h0, data: 64'h0, len: 8'(LINE_BEATS - 1), burst: BURST_INCR};
        state_d = fill_done ? RESPOND : REFILL;
      end
      RESPOND: begin
        bus.iresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: pick(buf_q, addr_q)};
        state_d = IDLE;
      end
      FLUSH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      addr_q <= '0;
      beat_q <= '0;
      pend_q <= 1'b0;
      for (int i = 0; i < NUM_SETS; i++) victim_q[i] <= '0;
    end else begin
      if (state_q == IDLE) addr_q <= bus.ireq.addr;
      pend_q <= !flush && (pend_q || (fence_i && state_q != IDLE));
      if (state_q == COMPARE) beat_q <= '0;
      else if (beat_ok) beat_q <= beat_q + 1'b1;
      if (fill_done && use_ptr) victim_q[idx] <= NUM_WAYS == 1 ? '0 : victim_q[idx] + 1'b1;
    end
  always_ff @(posedge clk)
    if (beat_ok) buf_q <= fill_line;
`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      hit_cnt <= '0;
      miss_cnt <= '0;
    end else if (state_q == COMPARE) begin
      if (hit && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
      if (!hit && miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
    end
`endif
endmodule
